qproc_time_base: RTL and testbench

Parametrised absolute-time base for the processor timing domain. Holds a free-running TIME_W-bit time counter with four controls: run, reset, initialise to an offset, and signed update. Adds a wrap indication and CMP_N armed time-compare channels that pulse when the counter reaches a programmed time. Sits in the t_clk domain and feeds time_abs_o to the dispatch and trigger logic.

---
 rtl/qproc_time_pkg.sv | 31 +++
 rtl/qproc_time_cmp.sv | 34 +++
 rtl/qproc_time_base.sv | 96 +++++++++
 tb/tb_qproc_time_base.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/qproc_time_pkg.sv
// Shared types and helpers for the processor time base: FSM state encoding, width-generic
// sign/zero extension (operands up to 64 bits), and the compare channel ceiling.
package qproc_time_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int CMP_N_MAX = 8;

  // Extend the low w bits of v to 64 bits; callers cast the result down to their own width.
  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = v;
    for (int b = 0; b < 64; b++) begin
      if (b >= w) r[b] = v[w-1];
    end
    return r;
  endfunction

  function automatic logic [63:0] zext(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = v;
    for (int b = 0; b < 64; b++) begin
      if (b >= w) r[b] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/qproc_time_cmp.sv
// One armed time-compare channel: hit pulses one cycle after time_abs reaches the target.
// Latency 1 cycle from condition to hit; no backpressure, an arm always wins over a pending hit.
module qproc_time_cmp #(
  parameter int TIME_W = 48
) (
  input  logic              t_clk_i,
  input  logic              t_rst_ni,
  input  logic              arm,
  input  logic [TIME_W-1:0] target_in,
  input  logic [TIME_W-1:0] time_abs,
  output logic              armed,
  output logic              hit
);

  logic [TIME_W-1:0] target_q;

  always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
    if (!t_rst_ni) begin
      target_q <= '0;
      armed    <= 1'b0;
      hit      <= 1'b0;
    end else if (arm) begin
      target_q <= target_in;
      armed    <= 1'b1;
      hit      <= 1'b0;
    end else if (armed && (time_abs >= target_q)) begin
      armed <= 1'b0;
      hit   <= 1'b1;
    end else begin
      hit <= 1'b0;
    end
  end

endmodule

// File: rtl/qproc_time_base.sv
// Free-running absolute time counter with run/reset/init/update controls, wrap pulse and
// optional compare channels (TIME_CMP_EN); 1-cycle command latency, no backpressure.
module qproc_time_base
  import qproc_time_pkg::*;
#(
  parameter int TIME_W = 48,
  parameter int DT_W   = 32,
  parameter int CMP_N  = 2
) (
  input  logic                    t_clk_i,
  input  logic                    t_rst_ni,
  input  logic                    time_en_i,
  input  logic                    time_rst_i,
  input  logic                    time_init_i,
  input  logic                    time_updt_i,
  input  logic [DT_W-1:0]         dt_i,
  input  logic [CMP_N*TIME_W-1:0] cmp_time_i,
  input  logic [CMP_N-1:0]        cmp_arm_i,
  output logic [TIME_W-1:0]       time_abs_o,
  output logic                    time_run_o,
  output logic                    time_wrap_o,
  output logic [CMP_N-1:0]        cmp_armed_o,
  output logic [CMP_N-1:0]        cmp_hit_o
);

  state_t            state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [TIME_W-1:0] dt_sx, dt_zx;
  logic [TIME_W:0]   updt_sum, inc_sum;
  logic              wrap_q, wrap_d;
  logic              run;

  assign run   = (state_q == ST_RUN);
  assign dt_sx = TIME_W'(sext(64'(dt_i), DT_W));
  assign dt_zx = TIME_W'(zext(64'(dt_i), DT_W));

  // The running tick rides along with an update so no count is lost.
  assign updt_sum = {1'b0, time_q} + {1'b0, dt_sx} + {{TIME_W{1'b0}}, run};
  assign inc_sum  = {1'b0, time_q} + {{TIME_W{1'b0}}, 1'b1};

  always_comb begin
    state_d = time_en_i ? ST_RUN : ST_IDLE;
    time_d  = time_q;
    wrap_d  = 1'b0;
    if (time_rst_i) begin
      time_d = '0;
    end else if (time_init_i) begin
      time_d = dt_zx;
    end else if (time_updt_i) begin
      time_d = updt_sum[TIME_W-1:0];
      // A negative operand borrows through the carry, so only a mismatch means a real wrap.
      wrap_d = updt_sum[TIME_W] ^ dt_i[DT_W-1];
    end else if (run) begin
      time_d = inc_sum[TIME_W-1:0];
      wrap_d = inc_sum[TIME_W];
    end
  end

  always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
    if (!t_rst_ni) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      wrap_q  <= wrap_d;
    end
  end

  assign time_abs_o  = time_q;
  assign time_run_o  = run;
  assign time_wrap_o = wrap_q;

`ifdef TIME_CMP_EN
  for (genvar g = 0; g < CMP_N; g++) begin : g_cmp
    qproc_time_cmp #(
      .TIME_W(TIME_W)
    ) u_cmp (
      .t_clk_i  (t_clk_i),
      .t_rst_ni (t_rst_ni),
      .arm      (cmp_arm_i[g]),
      .target_in(cmp_time_i[g*TIME_W +: TIME_W]),
      .time_abs (time_q),
      .armed    (cmp_armed_o[g]),
      .hit      (cmp_hit_o[g])
    );
  end
`else
  logic unused_cmp;
  assign unused_cmp  = ^{cmp_time_i, cmp_arm_i};
  assign cmp_armed_o = '0;
  assign cmp_hit_o   = '0;
`endif

endmodule

// File: tb/tb_qproc_time_base.sv
// Directed bench for qproc_time_base: a 48/32-bit instance for run, commands and compare,
// and an 8/8-bit instance for wrap behaviour.
module tb_qproc_time_base;

  logic t_clk_i = 1'b0;
  logic t_rst_ni = 1'b0;
  always #5 t_clk_i = ~t_clk_i;

  // wide instance
  logic        a_en, a_rst, a_init, a_updt;
  logic [31:0] a_dt;
  logic [95:0] a_cmp_time;
  logic [1:0]  a_arm;
  logic [47:0] a_time;
  logic        a_run, a_wrap;
  logic [1:0]  a_armed, a_hit;

  // narrow instance
  logic        b_en, b_rst, b_init, b_updt;
  logic [7:0]  b_dt;
  logic [7:0]  b_cmp_time;
  logic [0:0]  b_arm;
  logic [7:0]  b_time;
  logic        b_run, b_wrap;
  logic [0:0]  b_armed, b_hit;

  int n_chk = 0;
  int n_bad = 0;

`ifdef TIME_CMP_EN
  localparam bit CMP_ON = 1'b1;
`else
  localparam bit CMP_ON = 1'b0;
`endif

  qproc_time_base #(.TIME_W(48), .DT_W(32), .CMP_N(2)) u_dut_a (
    .t_clk_i(t_clk_i), .t_rst_ni(t_rst_ni),
    .time_en_i(a_en), .time_rst_i(a_rst), .time_init_i(a_init), .time_updt_i(a_updt),
    .dt_i(a_dt), .cmp_time_i(a_cmp_time), .cmp_arm_i(a_arm),
    .time_abs_o(a_time), .time_run_o(a_run), .time_wrap_o(a_wrap),
    .cmp_armed_o(a_armed), .cmp_hit_o(a_hit)
  );

  qproc_time_base #(.TIME_W(8), .DT_W(8), .CMP_N(1)) u_dut_b (
    .t_clk_i(t_clk_i), .t_rst_ni(t_rst_ni),
    .time_en_i(b_en), .time_rst_i(b_rst), .time_init_i(b_init), .time_updt_i(b_updt),
    .dt_i(b_dt), .cmp_time_i(b_cmp_time), .cmp_arm_i(b_arm),
    .time_abs_o(b_time), .time_run_o(b_run), .time_wrap_o(b_wrap),
    .cmp_armed_o(b_armed), .cmp_hit_o(b_hit)
  );

  task chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs set afterwards are sampled on the following edge.
  task tick();
    @(posedge t_clk_i);
    #1;
  endtask

  // expected compare outputs only exist when the channels are built
  function automatic logic [1:0] ce(input logic [1:0] v);
    return CMP_ON ? v : 2'b00;
  endfunction

  initial begin
    {a_en, a_rst, a_init, a_updt} = '0;
    a_dt = '0; a_cmp_time = '0; a_arm = '0;
    {b_en, b_rst, b_init, b_updt} = '0;
    b_dt = '0; b_cmp_time = '0; b_arm = '0;

    #1;
    chk("rst_time", {16'd0, a_time}, 64'd0);
    chk("rst_run_wrap", {62'd0, a_run, a_wrap}, 64'd0);
    chk("rst_cmp", {60'd0, a_armed, a_hit}, 64'd0);
    tick();
    tick();
    t_rst_ni = 1'b1;
    tick();
    chk("post_rst_hold", {16'd0, a_time}, 64'd0);

    // ---- wrap on the 8-bit instance ----
    b_init = 1'b1; b_dt = 8'd255;
    tick();
    b_init = 1'b0;
    chk("b_init255", {56'd0, b_time}, 64'd255);
    b_en = 1'b1;
    tick();
    chk("b_en_edge_hold", {56'd0, b_time}, 64'd255);
    tick();
    chk("b_wrap_time", {56'd0, b_time}, 64'd0);
    chk("b_wrap_pulse", {63'd0, b_wrap}, 64'd1);
    tick();
    chk("b_wrap_clear", {55'd0, b_time, b_wrap}, {55'd0, 8'd1, 1'b0});
    b_en = 1'b0;
    tick();
    chk("b_stop_time", {56'd0, b_time}, 64'd2);
    b_updt = 1'b1; b_dt = 8'hFB;
    tick();
    b_updt = 1'b0;
    chk("b_neg_updt", {56'd0, b_time}, 64'd253);
    chk("b_neg_wrap", {63'd0, b_wrap}, 64'd1);
    tick();
    chk("b_idle_hold", {55'd0, b_time, b_wrap}, {55'd0, 8'd253, 1'b0});
    chk("b_cmp_idle", {62'd0, b_armed, b_hit}, 64'd0);

    // ---- run / stop ----
    a_en = 1'b1;
    tick();
    chk("run_rise", {15'd0, a_run, a_time}, {15'd0, 1'b1, 48'd0});
    repeat (9) tick();
    chk("run_9", {16'd0, a_time}, 64'd9);
    a_en = 1'b0;
    tick();
    chk("run_fall", {15'd0, a_run, a_time}, {15'd0, 1'b0, 48'd10});
    tick();
    chk("run_hold", {16'd0, a_time}, 64'd10);

    // ---- init then signed update ----
    a_init = 1'b1; a_dt = 32'd1000;
    tick();
    a_init = 1'b0;
    chk("init_1000", {16'd0, a_time}, 64'd1000);
    a_en = 1'b1;
    tick();
    repeat (5) tick();
    chk("run_1005", {16'd0, a_time}, 64'd1005);
    a_updt = 1'b1; a_dt = 32'hFFFF_FFFD;
    tick();
    a_updt = 1'b0;
    chk("updt_1003", {16'd0, a_time}, 64'd1003);
    chk("updt_nowrap", {63'd0, a_wrap}, 64'd0);

    // ---- priority: rst beats init and updt ----
    {a_rst, a_init, a_updt} = 3'b111; a_dt = 32'd77;
    tick();
    {a_rst, a_init, a_updt} = 3'b000;
    chk("prio_zero", {16'd0, a_time}, 64'd0);
    tick();
    chk("prio_resume", {16'd0, a_time}, 64'd1);

    // ---- compare channels ----
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    repeat (10) tick();
    chk("cmp_start_time", {16'd0, a_time}, 64'd10);
    a_arm = 2'b11; a_cmp_time = {48'd5, 48'd20};
    tick();
    a_arm = 2'b00;
    chk("cmp_armed", {60'd0, a_armed, a_hit}, {60'd0, ce(2'b11), 2'b00});
    tick();
    chk("cmp_ch1_hit", {60'd0, a_armed, a_hit}, {60'd0, ce(2'b01), ce(2'b10)});
    tick();
    chk("cmp_ch1_pulse_end", {62'd0, a_hit}, 64'd0);
    repeat (7) tick();
    chk("cmp_at_20", {14'd0, a_armed, a_time}, {14'd0, ce(2'b01), 48'd20});
    chk("cmp_at_20_nohit", {62'd0, a_hit}, 64'd0);
    tick();
    chk("cmp_ch0_hit", {60'd0, a_armed, a_hit}, {60'd0, 2'b00, ce(2'b01)});
    tick();
    chk("cmp_done", {60'd0, a_armed, a_hit}, 64'd0);

    // ---- async reset mid-run ----
    a_init = 1'b1; a_dt = 32'd500;
    a_arm = 2'b01; a_cmp_time = {48'd0, 48'd10000};
    tick();
    a_init = 1'b0; a_arm = 2'b00;
    chk("pre_arst", {14'd0, a_armed, a_time}, {14'd0, ce(2'b01), 48'd500});
    #2;
    t_rst_ni = 1'b0;
    #1;
    chk("arst_time", {16'd0, a_time}, 64'd0);
    chk("arst_flags", {58'd0, a_run, a_wrap, a_armed, a_hit}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
